// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register match that never fires on x0.
  function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Operand source select; the younger MEM-stage result wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] mem_rd,
                                         input logic             mem_we,
                                         input logic [REG_W-1:0] wb_rd,
                                         input logic             wb_we);
    if (mem_we && reg_hit(mem_rd, rs)) return FWD_MEM;
    if (wb_we && reg_hit(wb_rd, rs))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select generation (purely combinational).
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_RegWrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_RegWrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  assign forward_a = fwd_sel(ex_rs1, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);
  assign forward_b = fwd_sel(ex_rs2, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: pipeline enables, flushes, forwarding, memory wait FSM.
// Build option HAZARD_FWD_EN: forwarding present, only load-use stalls; otherwise any RAW match stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWrite,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              freeze_c;
  logic              load_use_c;
  logic              stall_c;
  logic              unused_c;

  // True when the ID instruction reads a non-zero register equal to rd.
  function automatic logic id_reads(input logic [4:0] rd);
    return (id_use_rs1 && reg_hit(rd, id_rs1)) || (id_use_rs2 && reg_hit(rd, id_rs2));
  endfunction

  assign load_use_c = ex_MemRead && id_reads(ex_rd);

`ifdef HAZARD_FWD_EN
  forward_unit u_forward_unit (
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .mem_rd      (mem_rd),
    .mem_RegWrite(mem_RegWrite),
    .wb_rd       (wb_rd),
    .wb_RegWrite (wb_RegWrite),
    .forward_a   (forward_a),
    .forward_b   (forward_b)
  );

  assign stall_c  = load_use_c;
  assign unused_c = ex_RegWrite;
`else
  // Without forwarding every in-flight producer of an ID source must drain first.
  assign stall_c   = load_use_c
                   || (ex_RegWrite  && id_reads(ex_rd))
                   || (mem_RegWrite && id_reads(mem_rd))
                   || (wb_RegWrite  && id_reads(wb_rd));
  assign forward_a = FWD_RF;
  assign forward_b = FWD_RF;
  assign unused_c  = ^{ex_rs1, ex_rs2};
`endif

  assign freeze_c = ((state_q == RUN) && dmem_req && !dmem_ready)
                 || ((state_q == MEM_WAIT) && !dmem_ready);

  // Pin priority: error > memory freeze > branch flush > data-hazard stall > normal.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    if (state_q == ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (freeze_c) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall_c) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase

    stall_d = pc_en ? stall_q : stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule
